// File: rtl/bram_fifo_pkg.sv
// Shared constants and types for the BlockRAM_1KB FWFT FIFO controller.
// Geometry is 512 x 16-bit words, addressed as 256 rows x 2 halves.
package bram_fifo_pkg;

  localparam int PTR_W  = 9;
  localparam int ROW_W  = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam int CNT_W  = 10;

  localparam logic [5:0] CFG_16B = 6'b001010;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic row_t ptr_row(
    input ptr_t p
  );
    return p[PTR_W-1:1];
  endfunction

  function automatic logic [1:0] ptr_sel(
    input ptr_t p
  );
    return {1'b0, p[0]};
  endfunction

endpackage

// File: rtl/bram_fifo_skid.sv
// Two-entry output buffer fed by the RAM read pipeline.
// Head registers drive m_data/m_valid directly.
module bram_fifo_skid
  import bram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       load,
  input  word_t      load_data,
  input  logic       m_ready,
  output logic       m_valid,
  output word_t      m_data,
  output logic [1:0] occ
);

  word_t tail_q;
  logic  tail_v;
  logic  pop;

  assign pop = m_valid & m_ready;
  assign occ = {1'b0, m_valid} + {1'b0, tail_v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      tail_v  <= 1'b0;
      tail_q  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      tail_v  <= 1'b0;
      tail_q  <= '0;
    end else begin
      unique case (1'b1)
        pop && tail_v: begin
          m_data <= tail_q;
          tail_v <= load;
          if (load)
            tail_q <= load_data;
        end
        pop && !tail_v: begin
          m_valid <= load;
          if (load)
            m_data <= load_data;
        end
        !pop && load && !m_valid: begin
          m_valid <= 1'b1;
          m_data  <= load_data;
        end
        // Issue throttling guarantees the tail is free here.
        !pop && load && m_valid: begin
          tail_v <= 1'b1;
          tail_q <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Sequences one BlockRAM_1KB tile as a 512 x 16 FWFT FIFO.
// Optional level/almost_full ports: define BRAM_FIFO_LEVEL_EN.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int WR_EN_BIT  = 20,
  parameter int WR_SEL_LSB = 16,
  parameter int RD_SEL_LSB = 24,
  parameter int AF_LEVEL   = 496
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  bram_wr_addr,
  output logic [31:0] bram_wr_data,
  output logic [7:0]  bram_rd_addr,
  input  logic [31:0] bram_rd_data,
  output logic [5:0]  bram_cfg
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [9:0]  level,
  output logic        almost_full
`endif
);

  ptr_t       wptr;
  ptr_t       rptr;
  cnt_t       mem_cnt;
  logic       inflight;
  logic [1:0] skid_occ;
  logic       full;
  logic       push;
  logic       pop;
  logic       row_hit;
  logic       room;
  logic       issue;
  logic       rd_hi_unused;

  assign bram_cfg = CFG_16B;

  assign full    = (mem_cnt == cnt_t'(DEPTH));
  assign s_ready = ~rst & ~flush & ~full;
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // Reading the row being written this cycle is undefined on the tile.
  assign row_hit = push & (ptr_row(wptr) == ptr_row(rptr));

  assign room = ({1'b0, skid_occ} + {2'b0, inflight})
              < (3'd2 + {2'b0, pop});

  assign issue = ~rst & ~flush & room & ~row_hit
               & (mem_cnt != '0);

  assign bram_wr_addr = ptr_row(wptr);
  assign bram_rd_addr = ptr_row(rptr);

  always_comb begin
    bram_wr_data = '0;
    bram_wr_data[WR_SEL_LSB +: 2] = ptr_sel(wptr);
    bram_wr_data[RD_SEL_LSB +: 2] = ptr_sel(rptr);
    if (push) begin
      bram_wr_data[15:0]      = s_data;
      bram_wr_data[WR_EN_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (issue)
        rptr <= rptr + 1'b1;
      inflight <= issue;
      unique case (1'b1)
        push && !issue: mem_cnt <= mem_cnt + 1'b1;
        !push && issue: mem_cnt <= mem_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_hi_unused = ^bram_rd_data[31:16];

  bram_fifo_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (inflight),
    .load_data (bram_rd_data[15:0]),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .occ       (skid_occ)
  );

`ifdef BRAM_FIFO_LEVEL_EN
  cnt_t level_sum;

  assign level_sum = mem_cnt
                   + cnt_t'(inflight)
                   + cnt_t'(skid_occ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_sum;
      almost_full <= (level_sum >= cnt_t'(AF_LEVEL));
    end
  end
`else
  cnt_t af_unused;
  assign af_unused = cnt_t'(AF_LEVEL);
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl with a behavioural 512 x 16 tile model.
// Queue scoreboard, vector table and corner-case sequences.
module tb_bram_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  bram_wr_addr;
  logic [31:0] bram_wr_data;
  logic [7:0]  bram_rd_addr;
  logic [31:0] bram_rd_data;
  logic [5:0]  bram_cfg;

  bram_fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .bram_cfg     (bram_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile model: write enable and half selects embedded in wr_data.
  logic [15:0] ram [512];
  logic [15:0] rd_q;

  always_ff @(posedge clk) begin
    if (bram_wr_data[20])
      ram[{bram_wr_addr, bram_wr_data[16]}] <= bram_wr_data[15:0];
    rd_q <= ram[{bram_rd_addr, bram_wr_data[24]}];
  end

  assign bram_rd_data = {16'h0000, rd_q};

  int          n_cmp;
  int          n_bad;
  logic [15:0] q[$];
  int          wr_cnt;
  int          wr_bad;
  int          viol;
  logic        have_prev;
  logic        prev_hit;
  logic [8:0]  prev_rd;

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        mr;
    logic        ev;
    logic        cd;
    logic [15:0] ed;
    logic        es;
    logic        ew;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at the negedge: scoreboard and port-level monitors.
  task automatic obs();
    logic [8:0]  cur;
    logic [15:0] e;
    cur = {bram_rd_addr, bram_wr_data[24]};
    if (bram_wr_data[20])
      wr_cnt++;
    if (bram_wr_data[20] !== (s_valid && s_ready))
      wr_bad++;
    if (rst || flush) begin
      q.delete();
      have_prev = 1'b0;
      return;
    end
    if (have_prev && cur != prev_rd && prev_hit)
      viol++;
    have_prev = 1'b1;
    prev_rd   = cur;
    prev_hit  = bram_wr_data[20] && (bram_wr_addr == bram_rd_addr);
    if (m_valid && m_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_empty: got %0h want no pop", m_data);
      end else begin
        e = q.pop_front();
        chk("pop_data", {16'h0, m_data}, {16'h0, e});
      end
    end
    if (s_valid && s_ready)
      q.push_back(s_data);
  endtask

  task automatic tick();
    @(negedge clk);
    obs();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1'b1;
        return;
      end
      obs();
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_valid: got timeout want m_valid");
  endtask

  task automatic drain();
    m_ready = 1'b1;
    s_valid = 1'b0;
    for (int t = 0; t < 2000 && q.size() != 0; t++)
      tick();
    tick();
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int   acc;
    int   run;
    int   stale;
    logic ok;
    logic was_full;

    n_cmp = 0; n_bad = 0; wr_cnt = 0; wr_bad = 0; viol = 0;
    have_prev = 1'b0; prev_hit = 1'b0; prev_rd = '0;
    rst = 1'b1; flush = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    tbl[0]  = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1};
    tbl[1]  = '{1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0,    1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0};
    tbl[6]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1};
    tbl[7]  = '{1'b1, 16'h5678, 1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 1'b1};
    tbl[8]  = '{1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 1'b0};

    #2;
    chk("rst_m_valid", {31'h0, m_valid}, 0);
    chk("rst_m_data", {16'h0, m_data}, 0);
    chk("rst_s_ready", {31'h0, s_ready}, 0);
    chk("rst_wr_data", bram_wr_data, 0);
    chk("cfg", {26'h0, bram_cfg}, 32'h0A);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", {31'h0, s_ready}, 1);
    obs();
    @(posedge clk);
    #1;

    // Vector table: single push latency and back-to-back streaming.
    for (int i = 0; i < 12; i++) begin
      s_valid = tbl[i].sv;
      s_data  = tbl[i].sd;
      m_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_m_valid", i), {31'h0, m_valid}, {31'h0, tbl[i].ev});
      if (tbl[i].cd)
        chk($sformatf("tbl%0d_m_data", i), {16'h0, m_data}, {16'h0, tbl[i].ed});
      chk($sformatf("tbl%0d_s_ready", i), {31'h0, s_ready}, {31'h0, tbl[i].es});
      chk($sformatf("tbl%0d_wr_en", i), {31'h0, bram_wr_data[20]}, {31'h0, tbl[i].ew});
      obs();
      @(posedge clk);
      #1;
    end

    // Fill: 512 words land in RAM, two more fit in the skid.
    wr_cnt  = 0;
    acc     = 0;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int t = 0; t < 3000 && acc < 512; t++) begin
      s_data = 16'(acc + 1);
      @(negedge clk);
      if (s_valid && s_ready)
        acc++;
      obs();
      @(posedge clk);
      #1;
    end
    chk("fill_wr_en_cycles", wr_cnt, 512);
    was_full = 1'b0;
    for (int t = 0; t < 50 && !was_full; t++) begin
      s_data = 16'(acc + 1);
      @(negedge clk);
      was_full = !s_ready;
      if (s_valid && s_ready)
        acc++;
      obs();
      @(posedge clk);
      #1;
    end
    chk("capacity", acc, 514);

    m_ready = 1'b1;
    s_data  = 16'hDEAD;
    @(negedge clk);
    chk("full_pop_refuse", {31'h0, s_ready}, 0);
    obs();
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    run = 1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!m_valid)
        break;
      obs();
      run++;
      @(posedge clk);
      #1;
    end
    obs();
    @(posedge clk);
    #1;
    chk("drain_streak", run, 514);
    chk("fill_drained", q.size(), 0);
    @(negedge clk);
    chk("after_drain_m_valid", {31'h0, m_valid}, 0);
    obs();
    @(posedge clk);
    #1;

    // Random traffic at 50% duty on both sides.
    for (int t = 0; t < 5000; t++) begin
      s_valid = 1'($urandom % 2);
      s_data  = 16'($urandom);
      m_ready = 1'($urandom % 2);
      tick();
    end
    drain();
    chk("row_collisions", viol, 0);

    // Flush with 300 words held.
    acc     = 0;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int t = 0; t < 1000 && acc < 300; t++) begin
      s_data = 16'(acc + 16'h100);
      @(negedge clk);
      if (s_valid && s_ready)
        acc++;
      obs();
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_m_valid", {31'h0, m_valid}, 0);
    chk("flush_s_ready", {31'h0, s_ready}, 1);
    obs();
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 16'hA5A5;
    tick();
    s_data = 16'h5A5A;
    tick();
    s_valid = 1'b0;
    wait_valid(ok);
    if (ok)
      chk("flush_first", {16'h0, m_data}, 32'hA5A5);
    m_ready = 1'b1;
    obs();
    @(posedge clk);
    #1;
    drain();

    // Reset in the middle of streaming with reads in flight.
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      s_data = 16'($urandom);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", {31'h0, m_valid}, 0);
    chk("mid_rst_m_data", {16'h0, m_data}, 0);
    chk("mid_rst_s_ready", {31'h0, s_ready}, 0);
    chk("mid_rst_wr_data", bram_wr_data, 0);
    tick();
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    stale   = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (m_valid)
        stale++;
      obs();
      @(posedge clk);
      #1;
    end
    chk("no_stale", stale, 0);
    s_valid = 1'b1;
    s_data  = 16'h7777;
    tick();
    s_valid = 1'b0;
    wait_valid(ok);
    if (ok)
      chk("post_rst_first", {16'h0, m_data}, 32'h7777);
    obs();
    @(posedge clk);
    #1;
    drain();

    chk("wr_en_matches_accept", wr_bad, 0);
    chk("row_collisions_final", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
